// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: sequential fetch, stall hold, branch redirect, halt on HALT_WORD.
module fetch_stage #(
  parameter int               ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_dout,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              vld_q;
  logic [15:0]       count_q;
  logic              accept;

  assign instr       = imem_dout;
  assign instr_pc    = pc_q;
  assign fetch_count = count_q;
  assign accept      = instr_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Only an accepted HALT_WORD stops fetch; stalled or squashed ones do not.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (accept && (imem_dout == HALT_WORD)) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_addr   = RESET_VECTOR;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      BOOT: imem_addr = RESET_VECTOR;
      RUN: begin
        instr_valid = vld_q & ~branch_taken;
        if (branch_taken)  imem_addr = branch_target;
        else if (stall)    imem_addr = pc_q;
        else               imem_addr = pc_q + ADDR_W'(1);
      end
      HALTED: begin
        imem_addr = pc_q;
        halted    = 1'b1;
      end
      default: imem_addr = RESET_VECTOR;
    endcase
  end

  // pc_q tracks the address the memory latched, so it names the data on imem_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      vld_q   <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q  <= imem_addr;
      vld_q <= 1'b1;
      if (accept && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
  localparam int          AW = 10;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] instr_pc;
  logic [31:0]   imem_dout;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          halted;
  logic [15:0]   fetch_count;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  // model: 0 = boot, 1 = running, 2 = halted
  int m_state = 0;
  int m_pc = 0;
  int m_cnt = 0;

  fetch_stage #(.ADDR_W(AW), .RESET_VECTOR('0), .HALT_WORD(HW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic b, input int tgt);
    int   exp_addr;
    logic exp_valid;
    stall         = s;
    branch_taken  = b;
    branch_target = AW'(tgt);
    #1;
    case (m_state)
      0: begin exp_addr = 0; exp_valid = 1'b0; end
      1: begin
        exp_valid = !b;
        if (b)      exp_addr = tgt % 1024;
        else if (s) exp_addr = m_pc;
        else        exp_addr = (m_pc + 1) % 1024;
      end
      default: begin exp_addr = m_pc; exp_valid = 1'b0; end
    endcase
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("halted", 32'(halted), (m_state == 2) ? 32'd1 : 32'd0);
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
    chk("instr_pc", 32'(instr_pc), 32'(m_pc));
    if (m_state == 1) chk("instr", instr, mem[m_pc]);
    case (m_state)
      0: begin m_pc = 0; m_state = 1; end
      1: begin
        if (!b && !s) begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (mem[m_pc] == HW) m_state = 2;
        end
        m_pc = exp_addr;
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset between edges and releases it on the next falling edge.
  task automatic do_reset();
    stall = 1'b0;
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    m_state = 0;
    m_pc = 0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HW) mem[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    fill_mem();
    @(negedge clk);
    do_reset();

    // sequential fetch from reset
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 0);
    chk("count_after_8", 32'(fetch_count), 32'd8);

    // stall at pc 2, then branch over a stall at pc 4 with wrap-around
    do_reset();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    chk("stall_pc", 32'(instr_pc), 32'd2);
    chk("stall_instr", instr, 32'h102);
    step(1'b0, 1'b0, 0);
    chk("after_stall_pc", 32'(instr_pc), 32'd3);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 'h3FE);
    chk("branch_pc0", 32'(instr_pc), 32'h3FE);
    step(1'b0, 1'b0, 0);
    chk("branch_pc1", 32'(instr_pc), 32'h3FF);
    step(1'b0, 1'b0, 0);
    chk("branch_wrap", 32'(instr_pc), 32'h0);
    step(1'b0, 1'b0, 0);

    // halt word at 5, stalled once first
    mem[5] = HW;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk("halt_stalled", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 0);
    chk("halted", 32'(halted), 32'd1);
    step(1'b0, 1'b1, 9);
    step(1'b1, 1'b0, 0);
    chk("halt_count", 32'(fetch_count), 32'd6);
    do_reset();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("restart_pc", 32'(instr_pc), 32'd1);
    mem[5] = 32'h105;

    // randomized traffic with occasional halts
    do_reset();
    for (int i = 0; i < 1024; i++) if ($urandom_range(0, 99) == 0) mem[i] = HW;
    for (int i = 0; i < 600; i++) begin
      if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, int'($urandom_range(0, 1023)));
    end

    // counter saturation
    fill_mem();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    force dut.count_q = 16'hFFFD;
    #1 release dut.count_q;
    m_cnt = 65533;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0);
    chk("count_saturated", 32'(fetch_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
